// File: rtl/bus_burst_slave.sv
// ---------------------------------------------------------------------------
// bus_burst_slave
//
// Memory-mapped burst slave backed by an internal single-port word memory.
// A read command streams N consecutive words back on consecutive cycles
// while the slave stalls the bus. A write command stores its first beat in
// the accept cycle. The remaining beats then arrive whenever the master
// asserts s_write. Word pointers wrap modulo the memory depth.
//
// Parameters
//   MEM_WORDS    memory depth in 32-bit words (power of two)
//   BURST_WIDTH  width of s_burstCount (max burst 2^BURST_WIDTH-1 beats)
//
// Ports
//   clk                   single clock, rising edge
//   rest                  synchronous active-high reset
//   s_address             byte address; bits [log2(MEM_WORDS)+1:2] pick the word
//   s_byteEnable          per-byte write enable
//   s_read / s_write      command strobes (s_write also marks write beats)
//   s_writeData           write beat data
//   s_waitRequest         high while a read burst is streaming out
//   s_readData            read beat data, holds its value between beats
//   s_readDataValid       s_readData carries a beat this cycle
//   s_beginBurstTransfer  accepted for interface completeness, unused
//   s_burstCount          beats in the burst; 0 behaves as 1
// ---------------------------------------------------------------------------
module bus_burst_slave #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned BURST_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic [31:0]            s_address,
    input  logic [3:0]             s_byteEnable,
    input  logic                   s_read,
    input  logic                   s_write,
    input  logic [31:0]            s_writeData,
    output logic                   s_waitRequest,
    output logic [31:0]            s_readData,
    output logic                   s_readDataValid,
    input  logic                   s_beginBurstTransfer,
    input  logic [BURST_WIDTH-1:0] s_burstCount
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    localparam logic [IdxW-1:0]        PtrOne = IdxW'(1);
    localparam logic [BURST_WIDTH-1:0] CntOne = BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRdBurst,
        StWrBurst
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;

    logic [31:0]            mem [MEM_WORDS];

    // Single memory port: one address, at most one of read/write per cycle.
    logic                   mem_we;
    logic                   mem_re;
    logic [IdxW-1:0]        mem_addr;

    logic [IdxW-1:0]        cmd_idx;
    logic [BURST_WIDTH-1:0] cmd_beats;

    // Address bits above the word index and the burst-start marker carry no
    // meaning for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{s_address[31:IdxW+2], s_address[1:0], s_beginBurstTransfer};

    assign cmd_idx   = s_address[IdxW+1:2];
    assign cmd_beats = (s_burstCount == '0) ? CntOne : s_burstCount;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = ptr_q;

        unique case (state_q)
            StIdle: begin
                mem_addr = cmd_idx;
                // A write wins over a simultaneous read; the read is dropped.
                if (s_write) begin
                    mem_we = 1'b1;
                    if (cmd_beats != CntOne) begin
                        ptr_d   = cmd_idx + PtrOne;
                        cnt_d   = cmd_beats - CntOne;
                        state_d = StWrBurst;
                    end
                end else if (s_read) begin
                    // First beat is fetched now so it is valid next cycle.
                    mem_re   = 1'b1;
                    rvalid_d = 1'b1;
                    ptr_d    = cmd_idx + PtrOne;
                    cnt_d    = cmd_beats - CntOne;
                    state_d  = StRdBurst;
                end
            end

            StRdBurst: begin
                // cnt_q counts beats still to fetch after the one on the bus.
                if (cnt_q != '0) begin
                    mem_re   = 1'b1;
                    rvalid_d = 1'b1;
                    ptr_d    = ptr_q + PtrOne;
                    cnt_d    = cnt_q - CntOne;
                end else begin
                    state_d = StIdle;
                end
            end

            StWrBurst: begin
                // Address and read strobe are ignored; idle beats hold state.
                if (s_write) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + PtrOne;
                    cnt_d  = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        rdata_d = mem_re ? mem[mem_addr] : rdata_q;
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory array: never reset, so contents survive a bus reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we && !rest) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteEnable[b]) begin
                    mem[mem_addr][8*b +: 8] <= s_writeData[8*b +: 8];
                end
            end
        end
    end

    assign s_waitRequest   = (state_q == StRdBurst);
    assign s_readData      = rdata_q;
    assign s_readDataValid = rvalid_q;

endmodule
